// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod NUM_REQ).
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  int unsigned cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (k + ptr) % NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin burst sequencer in front of a byte-level SPI engine:
// grants one client, frames its chip select and streams len bytes through the engine.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 2
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*BYTE_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        tx_pop,
  output logic [BYTE_W-1:0]         rx_data,
  output logic [NUM_REQ-1:0]        rx_valid,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        cs_n,
  output logic                      spi_ena,
  output logic [BYTE_W-1:0]         spi_tx_byte,
  input  logic [BYTE_W-1:0]         spi_rx_byte,
  input  logic                      spi_new_byte
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int T_MAX = (CS_SETUP > CS_HOLD) ?
                         ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                         ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int CNT_W = $clog2(T_MAX + 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [LEN_W-1:0]   len_sel;
  logic [LEN_W-1:0]   len_grant;
  logic [BYTE_W-1:0]  tx_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    len_sel   = req_len[arb_idx*LEN_W +: LEN_W];
    len_grant = (len_sel > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_sel;
    tx_sel    = tx_data[gnt_q*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_q       <= '0;
      len_q       <= '0;
      remaining   <= '0;
      cnt         <= '0;
      cs_n        <= '1;
      spi_ena     <= 1'b0;
      spi_tx_byte <= '0;
      rx_data     <= '0;
      req_ready   <= '0;
      tx_pop      <= '0;
      rx_valid    <= '0;
      done        <= '0;
      busy        <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_pop    <= '0;
      rx_valid  <= '0;
      done      <= '0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            req_ready <= arb_gnt;
            rr_ptr    <= arb_idx;
            gnt_q     <= arb_idx;
            len_q     <= len_grant;
            busy      <= 1'b1;
            // Zero-length grants pass through HOLD with a zero count so done
            // lands one cycle after req_ready while cs_n stays high.
            if (len_grant == '0) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cs_n  <= ~arb_gnt;
              cnt   <= CNT_W'(CS_SETUP - 1);
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            spi_tx_byte   <= tx_sel;
            tx_pop[gnt_q] <= 1'b1;
            spi_ena       <= 1'b1;
            remaining     <= len_q;
            state         <= XFER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER: begin
          if (len_q == LEN_W'(1)) spi_ena <= 1'b0;
          if (spi_new_byte) begin
            rx_data         <= spi_rx_byte;
            rx_valid[gnt_q] <= 1'b1;
            remaining       <= remaining - 1'b1;
            if (remaining > LEN_W'(1)) begin
              spi_tx_byte   <= tx_sel;
              tx_pop[gnt_q] <= 1'b1;
            end
            // Engine samples ena at byte boundaries: dropping it here lets exactly one more byte run.
            if (remaining == LEN_W'(2)) spi_ena <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              cnt   <= CNT_W'(CS_HOLD - 1);
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs_n        <= '1;
            done[gnt_q] <= 1'b1;
            cnt         <= CNT_W'(CS_GAP - 1);
            state       <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a behavioural SPI engine whose slave echoes each byte.
module tb_spi_xfer_arbiter;

  localparam int NREQ  = 2;
  localparam int LW    = 5;
  localparam int SETUP_C = 4;
  localparam int HOLD_C  = 4;
  localparam int GAP_C   = 2;

  logic              clk;
  logic              arstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*8-1:0] tx_data;
  logic [NREQ-1:0]   tx_pop;
  logic [7:0]        rx_data;
  logic [NREQ-1:0]   rx_valid;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [NREQ-1:0]   cs_n;
  logic              spi_ena;
  logic [7:0]        spi_tx_byte;
  logic [7:0]        spi_rx_byte;
  logic              spi_new_byte;

  int checks = 0;
  int errors = 0;

  spi_xfer_arbiter #(
    .NUM_REQ  (NREQ),
    .MAX_LEN  (16),
    .CS_SETUP (SETUP_C),
    .CS_HOLD  (HOLD_C),
    .CS_GAP   (GAP_C)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_len      (req_len),
    .tx_data      (tx_data),
    .tx_pop       (tx_pop),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .done         (done),
    .busy         (busy),
    .cs_n         (cs_n),
    .spi_ena      (spi_ena),
    .spi_tx_byte  (spi_tx_byte),
    .spi_rx_byte  (spi_rx_byte),
    .spi_new_byte (spi_new_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine + loopback slave: ena is sampled when idle and at the end of each byte-complete cycle;
  // the byte to send is captured one cycle after that decision.
  logic [1:0] eng_st;
  logic [7:0] eng_sh;
  int         eng_cnt;
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      eng_st       <= 2'd0;
      eng_sh       <= 8'h00;
      eng_cnt      <= 0;
      spi_new_byte <= 1'b0;
      spi_rx_byte  <= 8'h00;
    end else begin
      spi_new_byte <= 1'b0;
      case (eng_st)
        2'd0: if (spi_ena) eng_st <= 2'd1;
        2'd1: begin eng_sh <= spi_tx_byte; eng_cnt <= 6; eng_st <= 2'd2; end
        2'd2: if (eng_cnt == 0) begin
                spi_new_byte <= 1'b1; spi_rx_byte <= eng_sh; eng_st <= 2'd3;
              end else eng_cnt <= eng_cnt - 1;
        default: eng_st <= spi_ena ? 2'd1 : 2'd0;
      endcase
    end
  end

  // Client tx byte sources, advanced on each tx_pop.
  logic [7:0] tx_mem [NREQ][64];
  int         tx_ptr [NREQ];
  always_comb
    for (int c = 0; c < NREQ; c++) tx_data[c*8 +: 8] = tx_mem[c][tx_ptr[c] % 64];

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int pop_cnt [NREQ], rxv_cnt [NREQ], done_cnt [NREQ];
  int fall_cyc [NREQ], rise_cyc [NREQ], rr_cyc [NREQ], done_cyc [NREQ];
  int nb_cnt = 0, nb_cyc = 0, ena_cyc_cnt = 0, ena_rise_cyc = 0;
  int overlap_cnt = 0, cs_low_cnt = 0, last_rise = 0;
  bit seen_low = 1'b0;
  logic [NREQ-1:0] cs_prev = '1;
  logic ena_prev = 1'b0;
  logic [7:0] rx_log0 [$];
  logic [7:0] rx_log1 [$];
  int grant_log [$];
  int gap_log [$];

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < NREQ; c++) begin
      if (tx_pop[c]) begin pop_cnt[c]++; tx_ptr[c]++; end
      if (rx_valid[c]) begin
        rxv_cnt[c]++;
        if (c == 0) rx_log0.push_back(rx_data); else rx_log1.push_back(rx_data);
      end
      if (done[c]) begin done_cnt[c]++; done_cyc[c] = cyc; end
      if (req_ready[c]) begin rr_cyc[c] = cyc; grant_log.push_back(c); end
      if (cs_prev[c] && !cs_n[c]) fall_cyc[c] = cyc;
      if (!cs_prev[c] && cs_n[c]) rise_cyc[c] = cyc;
    end
    if (spi_new_byte) begin nb_cnt++; nb_cyc = cyc; end
    if (spi_ena) ena_cyc_cnt++;
    if (spi_ena && !ena_prev) ena_rise_cyc = cyc;
    if (cs_n != '1) cs_low_cnt++;
    if (cs_n == '0) overlap_cnt++;
    if (cs_prev != '1 && cs_n == '1) last_rise = cyc;
    if (cs_prev == '1 && cs_n != '1 && seen_low) gap_log.push_back(cyc - last_rise);
    if (cs_n != '1) seen_low = 1'b1;
    cs_prev  = cs_n;
    ena_prev = spi_ena;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input int c, input int len);
    bit ok = 1'b0;
    req_len[c*LW +: LW] = LW'(len);
    req_valid[c] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (req_ready[c]) ok = 1'b1;
    end
    req_valid[c] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL req_ready%0d_timeout got 0 want 1 within 60 cycles", c); end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin tick(); i++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%0b want 0 after %0d cycles", busy, budget); end
    tick();
  endtask

  task automatic test_reset();
    arstn = 1'b0; req_valid = '0; req_len = '0;
    tick(); tick();
    checks++;
    if (cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n got %b want 11", cs_n); end
    checks++;
    if ({spi_ena, busy} !== 2'b00) begin errors++; $display("FAIL reset_ena_busy got %b want 00", {spi_ena, busy}); end
    checks++;
    if ({req_ready, tx_pop, rx_valid, done} !== 8'h00) begin
      errors++; $display("FAIL reset_pulses got %h want 00", {req_ready, tx_pop, rx_valid, done});
    end
    checks++;
    if ({rx_data, spi_tx_byte} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got %h want 0000", {rx_data, spi_tx_byte});
    end
    arstn = 1'b1;
    tick(); tick();
    checks++;
    if ({cs_n, busy} !== 3'b110) begin errors++; $display("FAIL idle_after_reset got %b want 110", {cs_n, busy}); end
  endtask

  task automatic test_round_robin();
    int g0, ov0, gp0, p0, p1, b0, b1;
    int exp_g [4];
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    exp_g = '{1, 0, 1, 0};
    e0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    e1 = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int k = 0; k < 4; k++) begin
      tx_mem[0][(tx_ptr[0] + k) % 64] = e0[k];
      tx_mem[1][(tx_ptr[1] + k) % 64] = e1[k];
    end
    g0 = grant_log.size(); ov0 = overlap_cnt; gp0 = gap_log.size();
    p0 = pop_cnt[0]; p1 = pop_cnt[1]; b0 = rx_log0.size(); b1 = rx_log1.size();
    req_len = {LW'(2), LW'(2)};
    req_valid = 2'b11;
    for (int i = 0; i < 1000 && grant_log.size() - g0 < 4; i++) tick();
    req_valid = '0;
    checks++;
    if (grant_log.size() - g0 != 4) begin
      errors++; $display("FAIL rr_grants got %0d want 4", grant_log.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[g0 + k] !== exp_g[k]) begin
          errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_log[g0 + k], exp_g[k]);
        end
      end
    end
    wait_idle(300);
    checks++;
    if ((pop_cnt[0] - p0 != 4) || (pop_cnt[1] - p1 != 4)) begin
      errors++; $display("FAIL rr_tx_pop got %0d/%0d want 4/4", pop_cnt[0] - p0, pop_cnt[1] - p1);
    end
    checks++;
    if (overlap_cnt - ov0 != 0) begin errors++; $display("FAIL rr_cs_overlap got %0d want 0", overlap_cnt - ov0); end
    checks++;
    if (gap_log.size() - gp0 != 3) begin
      errors++; $display("FAIL rr_gap_count got %0d want 3", gap_log.size() - gp0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gap_log[gp0 + k] < GAP_C) begin
          errors++; $display("FAIL rr_cs_gap[%0d] got %0d want >=%0d", k, gap_log[gp0 + k], GAP_C);
        end
      end
    end
    checks++;
    if ((rx_log0.size() - b0 != 4) || (rx_log1.size() - b1 != 4)) begin
      errors++; $display("FAIL rr_rx_count got %0d/%0d want 4/4", rx_log0.size() - b0, rx_log1.size() - b1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ((rx_log0[b0 + k] !== e0[k]) || (rx_log1[b1 + k] !== e1[k])) begin
          errors++; $display("FAIL rr_rx[%0d] got %h/%h want %h/%h", k, rx_log0[b0 + k], rx_log1[b1 + k], e0[k], e1[k]);
        end
      end
    end
  endtask

  task automatic test_single();
    int p0, r0, d0, nb0, rb;
    logic [7:0] e [3];
    e = '{8'hA5, 8'h3C, 8'hFF};
    for (int k = 0; k < 3; k++) tx_mem[0][(tx_ptr[0] + k) % 64] = e[k];
    p0 = pop_cnt[0]; r0 = rxv_cnt[0]; d0 = done_cnt[0]; nb0 = nb_cnt; rb = rx_log0.size();
    do_req(0, 3);
    wait_idle(400);
    checks++;
    if (pop_cnt[0] - p0 != 3) begin errors++; $display("FAIL single_tx_pop got %0d want 3", pop_cnt[0] - p0); end
    checks++;
    if (rxv_cnt[0] - r0 != 3) begin errors++; $display("FAIL single_rx_valid got %0d want 3", rxv_cnt[0] - r0); end
    checks++;
    if (nb_cnt - nb0 != 3) begin errors++; $display("FAIL single_new_byte got %0d want 3", nb_cnt - nb0); end
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt[0] - d0); end
    checks++;
    if (ena_rise_cyc - fall_cyc[0] != SETUP_C) begin
      errors++; $display("FAIL single_cs_setup got %0d want %0d", ena_rise_cyc - fall_cyc[0], SETUP_C);
    end
    checks++;
    if (rise_cyc[0] - nb_cyc - 1 != HOLD_C) begin
      errors++; $display("FAIL single_cs_hold got %0d want %0d", rise_cyc[0] - nb_cyc - 1, HOLD_C);
    end
    checks++;
    if (done_cyc[0] != rise_cyc[0]) begin
      errors++; $display("FAIL single_done_at_cs_rise got %0d want %0d", done_cyc[0], rise_cyc[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_log0.size() <= rb + k) begin
        errors++; $display("FAIL single_rx[%0d] got none want %h", k, e[k]);
      end else if (rx_log0[rb + k] !== e[k]) begin
        errors++; $display("FAIL single_rx[%0d] got %h want %h", k, rx_log0[rb + k], e[k]);
      end
    end
  endtask

  task automatic test_len1();
    int en0, nb0, r1, rb;
    tx_mem[1][tx_ptr[1] % 64] = 8'h5A;
    en0 = ena_cyc_cnt; nb0 = nb_cnt; r1 = rxv_cnt[1]; rb = rx_log1.size();
    do_req(1, 1);
    wait_idle(200);
    checks++;
    if (ena_cyc_cnt - en0 != 1) begin errors++; $display("FAIL len1_ena_cycles got %0d want 1", ena_cyc_cnt - en0); end
    checks++;
    if (nb_cnt - nb0 != 1) begin errors++; $display("FAIL len1_new_byte got %0d want 1", nb_cnt - nb0); end
    checks++;
    if (rxv_cnt[1] - r1 != 1) begin errors++; $display("FAIL len1_rx_valid got %0d want 1", rxv_cnt[1] - r1); end
    checks++;
    if (rx_log1.size() <= rb) begin
      errors++; $display("FAIL len1_rx got none want 5a");
    end else if (rx_log1[rb] !== 8'h5A) begin
      errors++; $display("FAIL len1_rx got %h want 5a", rx_log1[rb]);
    end
  endtask

  task automatic test_zero_len();
    int cl0, en0, d1;
    cl0 = cs_low_cnt; en0 = ena_cyc_cnt; d1 = done_cnt[1];
    do_req(1, 0);
    wait_idle(50);
    checks++;
    if (done_cnt[1] - d1 != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_cnt[1] - d1); end
    checks++;
    if (done_cyc[1] - rr_cyc[1] != 1) begin
      errors++; $display("FAIL zero_done_latency got %0d want 1", done_cyc[1] - rr_cyc[1]);
    end
    checks++;
    if (cs_low_cnt - cl0 != 0) begin errors++; $display("FAIL zero_cs_activity got %0d want 0", cs_low_cnt - cl0); end
    checks++;
    if (ena_cyc_cnt - en0 != 0) begin errors++; $display("FAIL zero_spi_ena got %0d want 0", ena_cyc_cnt - en0); end
  endtask

  task automatic test_max_len();
    int p0, nb0, d0, rb;
    for (int k = 0; k < 20; k++) tx_mem[0][(tx_ptr[0] + k) % 64] = 8'(8'h80 + k);
    p0 = pop_cnt[0]; nb0 = nb_cnt; d0 = done_cnt[0]; rb = rx_log0.size();
    do_req(0, 20);
    wait_idle(600);
    checks++;
    if (nb_cnt - nb0 != 16) begin errors++; $display("FAIL max_new_byte got %0d want 16", nb_cnt - nb0); end
    checks++;
    if (pop_cnt[0] - p0 != 16) begin errors++; $display("FAIL max_tx_pop got %0d want 16", pop_cnt[0] - p0); end
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL max_done got %0d want 1", done_cnt[0] - d0); end
    checks++;
    if (rx_log0.size() - rb != 16) begin
      errors++; $display("FAIL max_rx_count got %0d want 16", rx_log0.size() - rb);
    end else if (rx_log0[rb + 15] !== 8'h8F) begin
      errors++; $display("FAIL max_rx_last got %h want 8f", rx_log0[rb + 15]);
    end
  endtask

  task automatic test_reset_mid();
    int nb0, p0, d0, rb, i;
    for (int k = 0; k < 4; k++) tx_mem[0][(tx_ptr[0] + k) % 64] = 8'(8'h01 + k);
    nb0 = nb_cnt;
    do_req(0, 4);
    i = 0;
    while (nb_cnt - nb0 < 1 && i < 100) begin tick(); i++; end
    checks++;
    if (nb_cnt - nb0 < 1) begin errors++; $display("FAIL mid_first_byte got %0d want 1", nb_cnt - nb0); end
    tick(); tick(); tick();
    arstn = 1'b0;
    #1;
    checks++;
    if ({cs_n, spi_ena, busy} !== 4'b1100) begin
      errors++; $display("FAIL mid_reset_outputs got %b want 1100", {cs_n, spi_ena, busy});
    end
    tick();
    arstn = 1'b1;
    tick(); tick();
    tx_mem[0][tx_ptr[0] % 64]       = 8'hC3;
    tx_mem[0][(tx_ptr[0] + 1) % 64] = 8'h3C;
    p0 = pop_cnt[0]; d0 = done_cnt[0]; rb = rx_log0.size(); nb0 = nb_cnt;
    do_req(0, 2);
    wait_idle(300);
    checks++;
    if ((pop_cnt[0] - p0 != 2) || (nb_cnt - nb0 != 2) || (done_cnt[0] - d0 != 1)) begin
      errors++; $display("FAIL post_reset_xfer got pop=%0d nb=%0d done=%0d want 2 2 1",
                         pop_cnt[0] - p0, nb_cnt - nb0, done_cnt[0] - d0);
    end
    checks++;
    if (rx_log0.size() - rb != 2) begin
      errors++; $display("FAIL post_reset_rx_count got %0d want 2", rx_log0.size() - rb);
    end else if ({rx_log0[rb], rx_log0[rb + 1]} !== 16'hC33C) begin
      errors++; $display("FAIL post_reset_rx got %h%h want c33c", rx_log0[rb], rx_log0[rb + 1]);
    end
  endtask

  initial begin
    arstn     = 1'b0;
    req_valid = '0;
    req_len   = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_len1();
    test_zero_len();
    test_max_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
